// File: rtl/airlock_input_conditioner.sv
// Input conditioning and time base: per-bit polarity fix, 2-flop sync, debounce with
// press/release pulses, plus a single-cycle tick every TICK_DIV clocks.
module airlock_input_conditioner #(
   parameter int unsigned          N_IN      = 4,
   parameter logic [N_IN-1:0]      INVERT    = {N_IN{1'b1}},
   parameter int unsigned          DB_CYCLES = 250000,
   parameter int unsigned          TICK_DIV  = 50000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_IN-1:0] raw_in,
   input  logic            tick_clr,
   output logic [N_IN-1:0] level,
   output logic [N_IN-1:0] press,
   // "release" is a reserved word, hence the suffix
   output logic [N_IN-1:0] release_pulse,
   output logic            tick
);

   localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
   localparam int unsigned DIV_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

   logic [N_IN-1:0]             s1_q, s1_d;
   logic [N_IN-1:0]             s2_q, s2_d;
   logic [N_IN-1:0]             level_q, level_d;
   logic [N_IN-1:0]             press_q, press_d;
   logic [N_IN-1:0]             release_q, release_d;
   logic [N_IN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]            div_q, div_d;
   logic                        tick_q, tick_d;

   always_comb begin
      s1_d      = raw_in ^ INVERT;
      s2_d      = s1_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      cnt_d     = cnt_q;
      for (int i = 0; i < int'(N_IN); i++) begin
         if (s2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            level_d[i]   = s2_q[i];
            cnt_d[i]     = '0;
            press_d[i]   = s2_q[i];
            release_d[i] = ~s2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end

      // Restart has priority over wrap so a started timer gets a full first period
      if (tick_clr) begin
         div_d  = '0;
         tick_d = 1'b0;
      end else if (div_q == DIV_MAX) begin
         div_d  = '0;
         tick_d = 1'b1;
      end else begin
         div_d  = div_q + DIV_W'(1);
         tick_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q      <= '0;
         s2_q      <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         cnt_q     <= '0;
         div_q     <= '0;
         tick_q    <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         tick_q    <= tick_d;
      end
   end

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign tick          = tick_q;

endmodule

// File: tb/tb_airlock_input_conditioner.sv
// Directed bench for airlock_input_conditioner with N_IN=4, INVERT=0011, DB_CYCLES=4,
// TICK_DIV=5. Inputs change and outputs are sampled on the falling edge.
module tb_airlock_input_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] raw_in;
   logic       tick_clr;
   logic [3:0] level;
   logic [3:0] press;
   logic [3:0] release_pulse;
   logic       tick;

   int total = 0;
   int bad   = 0;

   localparam logic [3:0] IDLE_RAW = 4'b0011;

   airlock_input_conditioner #(
      .N_IN      (4),
      .INVERT    (4'b0011),
      .DB_CYCLES (4),
      .TICK_DIV  (5)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .raw_in        (raw_in),
      .tick_clr      (tick_clr),
      .level         (level),
      .press         (press),
      .release_pulse (release_pulse),
      .tick          (tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [3:0] raw, input int cycles);
      raw_in   = raw;
      tick_clr = 1'b0;
      reset    = 1'b1;
      repeat (cycles) step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(4'b1100, 0);
      reset = 1'b1;
      for (int e = 0; e < 3; e++) begin
         step();
         total++;
         if ({level, press, release_pulse, tick} !== 13'd0) begin
            bad++;
            $display("FAIL reset_hold edge=%0d outs=%b required=0", e,
                     {level, press, release_pulse, tick});
         end
      end
      reset = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         step();
         total++;
         if (level !== ((e >= 6) ? 4'b1111 : 4'b0000) ||
             press !== ((e == 6) ? 4'b1111 : 4'b0000) || release_pulse !== 4'b0000) begin
            bad++;
            $display("FAIL reset_active_in edge=%0d level=%b press=%b rel=%b", e, level, press,
                     release_pulse);
         end
         if (e < 5) begin
            total++;
            if (tick !== 1'b0) begin
               bad++;
               $display("FAIL reset_tick edge=%0d tick=%b required=0", e, tick);
            end
         end
      end
   endtask

   task automatic test_press_release();
      do_reset(IDLE_RAW, 2);
      repeat (8) step();
      raw_in[0] = 1'b0;
      for (int e = 0; e <= 6; e++) begin
         step();
         total++;
         if (level !== ((e >= 5) ? 4'b0001 : 4'b0000) ||
             press !== ((e == 5) ? 4'b0001 : 4'b0000) || release_pulse !== 4'b0000) begin
            bad++;
            $display("FAIL press_bit0 edge=%0d level=%b press=%b rel=%b", e, level, press,
                     release_pulse);
         end
      end
      raw_in[0] = 1'b1;
      for (int e = 0; e <= 6; e++) begin
         step();
         total++;
         if (level !== ((e >= 5) ? 4'b0000 : 4'b0001) || press !== 4'b0000 ||
             release_pulse !== ((e == 5) ? 4'b0001 : 4'b0000)) begin
            bad++;
            $display("FAIL release_bit0 edge=%0d level=%b press=%b rel=%b", e, level, press,
                     release_pulse);
         end
      end
   endtask

   task automatic test_glitch();
      int np;
      int nr;
      raw_in[1] = 1'b0;
      repeat (3) step();
      raw_in[1] = 1'b1;
      for (int e = 0; e < 10; e++) begin
         step();
         total++;
         if (level[1] !== 1'b0 || press[1] !== 1'b0 || release_pulse[1] !== 1'b0) begin
            bad++;
            $display("FAIL glitch_short edge=%0d level=%b press=%b rel=%b", e, level, press,
                     release_pulse);
         end
      end
      np = 0;
      nr = 0;
      raw_in[1] = 1'b0;
      for (int e = 0; e <= 20; e++) begin
         step();
         if (e == 4) raw_in[1] = 1'b1;
         if (press[1]) begin
            np++;
            total++;
            if (e != 5) begin
               bad++;
               $display("FAIL glitch_long_press_time edge=%0d required=5", e);
            end
         end
         if (release_pulse[1]) begin
            nr++;
            total++;
            if (e != 10) begin
               bad++;
               $display("FAIL glitch_long_release_time edge=%0d required=10", e);
            end
         end
      end
      total++;
      if (np != 1 || nr != 1 || level !== 4'b0000) begin
         bad++;
         $display("FAIL glitch_long presses=%0d releases=%0d level=%b required 1 1 0000", np, nr,
                  level);
      end
   endtask

   task automatic test_simultaneous();
      raw_in = 4'b1010;
      for (int e = 0; e <= 6; e++) begin
         step();
         total++;
         if (level !== ((e >= 5) ? 4'b1001 : 4'b0000) ||
             press !== ((e == 5) ? 4'b1001 : 4'b0000)) begin
            bad++;
            $display("FAIL simultaneous edge=%0d level=%b press=%b", e, level, press);
         end
      end
      raw_in = IDLE_RAW;
      repeat (10) step();
   endtask

   task automatic test_reset_mid_debounce();
      do_reset(IDLE_RAW, 2);
      repeat (8) step();
      raw_in = 4'b0111;
      repeat (3) step();
      reset = 1'b1;
      for (int e = 3; e <= 4; e++) begin
         step();
         total++;
         if (press !== 4'b0000 || level !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset_hold edge=%0d level=%b press=%b", e, level, press);
         end
      end
      reset = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         step();
         total++;
         if (level !== ((e >= 6) ? 4'b0100 : 4'b0000) ||
             press !== ((e == 6) ? 4'b0100 : 4'b0000)) begin
            bad++;
            $display("FAIL mid_reset_after edge=%0d level=%b press=%b", e, level, press);
         end
      end
   endtask

   task automatic test_tick();
      logic exp;
      do_reset(IDLE_RAW, 2);
      for (int e = 1; e <= 28; e++) begin
         tick_clr = (e == 12 || e == 22);
         step();
         exp = (e == 5 || e == 10 || e == 17 || e == 27);
         total++;
         if (tick !== exp) begin
            bad++;
            $display("FAIL tick edge=%0d tick=%b required=%b", e, tick, exp);
         end
      end
      tick_clr = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      raw_in   = IDLE_RAW;
      tick_clr = 1'b0;
      @(negedge clk);
      test_reset();
      test_press_release();
      test_glitch();
      test_simultaneous();
      test_reset_mid_debounce();
      test_tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/airlock_input_conditioner.md
# airlock_input_conditioner

Input conditioning and time-base stage for the airlock controller. Takes raw board inputs (active-low pushbuttons and slide switches), synchronizes and debounces them, and emits clean levels plus one-cycle press/release pulses to the interlock FSM and its countdown timers. It also generates a single-cycle seconds tick so that downstream counters run on the system clock with an enable, not on a divided clock.

## Interface
- N_IN, 4, number of raw inputs conditioned.
- INVERT, {N_IN{1'b1}}, per-bit mask; 1 = raw input is active-low (KEY), 0 = active-high (SW).
- DB_CYCLES, 250000, consecutive cycles a new synchronized value must persist before it is accepted (5 ms at 50 MHz); legal range ≥1.
- TICK_DIV, 50000000, clock cycles per tick period; legal range ≥2.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- raw_in  in  N_IN  asynchronous board inputs.
- tick_clr  in  1  synchronous restart of the tick divider (asserted when a timer is started so its first second is full length).
- level  out  N_IN  debounced, polarity-corrected input (1 = pressed/on).
- press  out  N_IN  one-cycle pulse on each 0→1 transition of level.
- release  out  N_IN  one-cycle pulse on each 1→0 transition of level.
- tick  out  1  one-cycle pulse every TICK_DIV cycles.

## Operation
- Per bit: polarity correction (XOR with INVERT), then a two-flop synchronizer (s1, s2), then a debounce counter cnt of width $clog2(DB_CYCLES+1).
- Debounce, evaluated each edge: if s2 == level, cnt←0. Else if cnt == DB_CYCLES-1: level←s2, cnt←0, and press or release pulses according to the new value. Else cnt←cnt+1.
- A mismatch that disappears before acceptance clears cnt. Glitches shorter than DB_CYCLES synchronized cycles never reach level.
- press and release are registered. Each is high only in the cycle immediately following the edge at which level changed. They are never high simultaneously for the same bit.
- Bits are fully independent, so simultaneous changes on different bits produce simultaneous pulses.
- Tick divider div, width $clog2(TICK_DIV):
  - tick_clr=1: div←0, tick←0. tick_clr has priority over wrap.
  - Else if div == TICK_DIV-1: div←0, tick←1.
  - Else: div←div+1, tick←0.
- Reset, synchronous:
  - s1 and s2 load 0, which is the inactive level after polarity correction.
  - level=0, press=0, release=0, cnt=0, div=0, tick=0.
  - An input held active through reset is therefore accepted as a fresh press after the debounce latency.
- Reset during an ongoing debounce or divide discards progress. No pulse is emitted in the reset cycle or in the first cycle after reset.

## Timing
- Edge numbering: raw_in reaches its new value before edge 0, and edge 0 samples it into s1.
- s2 holds the new value after edge 1.
- level changes, and press/release rise, after edge DB_CYCLES+1. They are visible during the following cycle. press/release fall after edge DB_CYCLES+2.
- Total acceptance latency is DB_CYCLES+2 cycles from raw change to visible level.
- Tick: with the first post-reset edge numbered edge 1, ticks are visible after edges TICK_DIV, 2·TICK_DIV, and so on. After tick_clr is sampled at edge c, the next tick is visible after edge c+TICK_DIV.
- There is no combinational path from any input to any output.

## Test plan
Parameters for all cases: N_IN=4, INVERT=4'b0011, DB_CYCLES=4, TICK_DIV=5.

- **Reset with inputs active:** hold reset 3 cycles with raw_in=4'b1100 (all active), then release.
  - Every output is 0 during reset and in the first cycle after release.
  - level goes to 4'b1111 and press=4'b1111 for exactly one cycle, 6 cycles after release (edge 5 is the first sampling edge).
- **Clean press and release on bit 0:** drive raw_in[0] 1→0.
  - level[0]=1 and press[0]=1 after edge 5; press[0] returns to 0 after edge 6.
  - Then drive 0→1: release[0] pulses once at the same latency.
- **Glitch rejection:** pulse raw_in[1] active for 3 cycles, then inactive.
  - level[1], press[1] and release[1] stay 0.
  - A 5-cycle pulse instead produces exactly one press and, later, one release.
- **Simultaneous events:** toggle bits 0 and 3 to active on the same edge.
  - press=4'b1001 for one cycle; bits 1 and 2 stay 0.
- **Tick and tick_clr:** free-running tick is visible after edges 5, 10 and 15.
  - Assert tick_clr at edge 12: the tick expected after edge 15 is suppressed, and the next tick follows edge 17.
  - tick_clr held high on the wrap edge yields tick=0.
- **Reset mid-debounce:** start a press on bit 2, then assert reset at edge 3.
  - No press is emitted during reset.
  - With raw still active after release, press[2] appears 6 cycles after release, not earlier.
